// File: rtl/pc_ctrl_if.sv
// Bundle of the branch/hazard control signals between the pipeline and pc_ctrl.
// The controller connects through the slave modport; the pipeline side uses master.
interface pc_ctrl_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            br_valid;
  logic            branch_taken;
  logic [PC_W-1:0] br_target;
  logic            cc_pending;
  logic            cnt_clr;
  logic [PC_W-1:0] pc;
  logic            if_flush;
  logic            hold_dec;
  logic            redirect;
  logic [15:0]     br_count;

  modport slave (
    input  stall, br_valid, branch_taken, br_target, cc_pending, cnt_clr,
    output pc, if_flush, hold_dec, redirect, br_count
  );

  modport master (
    output stall, br_valid, branch_taken, br_target, cc_pending, cnt_clr,
    input  pc, if_flush, hold_dec, redirect, br_count
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch PC controller: sequential fetch, conditional-branch redirect with one-cycle
// IF squash, wait state for pending condition codes, and a saturating taken-branch count.
module pc_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst,
  pc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_CC = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     br_count_q, br_count_d;
  logic            redirect_d;
  logic            take_branch;

  assign take_branch = bus.br_valid && bus.branch_taken;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (bus.br_valid && bus.cc_pending) begin
            state_d = WAIT_CC;
          end else if (take_branch) begin
            pc_d       = bus.br_target;
            redirect_d = 1'b1;
            state_d    = FLUSH;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      WAIT_CC: begin
        if (!bus.stall) begin
          if (take_branch) begin
            pc_d       = bus.br_target;
            redirect_d = 1'b1;
            state_d    = FLUSH;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pc_d    = pc_q + 1'b1;
          state_d = RUN;
        end
      end
      // Illegal encoding: return to RUN even under stall so the FSM cannot lock up.
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    br_count_d = br_count_q;
    if (bus.cnt_clr) begin
      br_count_d = '0;
    end else if (redirect_d && (br_count_q != 16'hFFFF)) begin
      br_count_d = br_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      br_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      br_count_q <= br_count_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.if_flush = (state_q == FLUSH);
  assign bus.hold_dec = (state_q == WAIT_CC);
  // Mask redirect during reset so a branch presented then never appears taken.
  assign bus.redirect = redirect_d && !rst;
  assign bus.br_count = br_count_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: fetch, taken/not-taken branches, flag hazard,
// stall, counter saturation/clear, PC wrap and asynchronous reset.
module tb_pc_ctrl;
  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_ctrl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic bt, input logic [31:0] tgt,
                       input logic cc, input logic st, input logic clr);
    bus.br_valid     = bv;
    bus.branch_taken = bt;
    bus.br_target    = tgt;
    bus.cc_pending   = cc;
    bus.stall        = st;
    bus.cnt_clr      = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_pc,
                             input logic exp_flush, input logic exp_hold);
    chk({tag, ".pc"}, bus.pc, exp_pc);
    chk({tag, ".if_flush"}, {31'd0, bus.if_flush}, {31'd0, exp_flush});
    chk({tag, ".hold_dec"}, {31'd0, bus.hold_dec}, {31'd0, exp_hold});
  endtask

  initial begin
    // Reset with a taken branch presented: nothing may redirect
    drive(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_state("rst", RESET_PC, 1'b0, 1'b0);
    chk("rst.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst.br_count", {16'd0, bus.br_count}, 32'd0);
    idle();
    rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_state($sformatf("seq%0d", i), RESET_PC + 32'(i), 1'b0, 1'b0);
    end

    // Branch to 0x1F, clear counter during the flush cycle -> pc 0x20 in RUN
    drive(1'b1, 1'b1, 32'h1F, 1'b0, 1'b0, 1'b0);
    chk("br1f.redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    check_state("br1f.flush", 32'h1F, 1'b1, 1'b0);
    chk("br1f.count", {16'd0, bus.br_count}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check_state("clr.run", 32'h20, 1'b0, 1'b0);
    chk("clr.count", {16'd0, bus.br_count}, 32'd0);

    // Taken branch 0x20 -> 0x80
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("tk.redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    idle();
    check_state("tk.flush", 32'h80, 1'b1, 1'b0);
    chk("tk.count", {16'd0, bus.br_count}, 32'd1);
    tick();
    check_state("tk.next", 32'h81, 1'b0, 1'b0);

    // Target equal to pc+1 is still a taken branch
    drive(1'b1, 1'b1, 32'h82, 1'b0, 1'b0, 1'b0);
    chk("tp1.redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    check_state("tp1.flush", 32'h82, 1'b1, 1'b0);
    chk("tp1.count", {16'd0, bus.br_count}, 32'd2);

    // Stall for 3 cycles in FLUSH with a branch presented
    drive(1'b1, 1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("stall%0d.redirect", i), {31'd0, bus.redirect}, 32'd0);
      tick();
      check_state($sformatf("stall%0d", i), 32'h82, 1'b1, 1'b0);
    end
    chk("stall.count", {16'd0, bus.br_count}, 32'd2);
    idle();
    tick();
    check_state("stall.run", 32'h83, 1'b0, 1'b0);

    // Reach pc 0x10
    drive(1'b1, 1'b1, 32'h0F, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check_state("to10", 32'h10, 1'b0, 1'b0);

    // Flag hazard, resolved not taken (cc_pending wins over taken in RUN)
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("hz.redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    check_state("hz.wait", 32'h10, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("hznt.redirect", {31'd0, bus.redirect}, 32'd0);
    tick();
    idle();
    check_state("hznt.run", 32'h11, 1'b0, 1'b0);

    // Flag hazard, resolved taken
    drive(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0);
    tick();
    check_state("hz2.wait", 32'h11, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    chk("hzt.redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    idle();
    check_state("hzt.flush", 32'h40, 1'b1, 1'b0);
    chk("hzt.count", {16'd0, bus.br_count}, 32'd4);
    tick();
    check_state("hzt.next", 32'h41, 1'b0, 1'b0);

    // Counter saturation: preload 0xFFFE then take 3 branches
    force dut.br_count_q = 16'hFFFE;
    #1;
    release dut.br_count_q;
    #1;
    chk("sat.preload", {16'd0, bus.br_count}, 32'hFFFE);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk($sformatf("sat%0d.count", i), {16'd0, bus.br_count}, 32'hFFFF);
      tick();
    end

    // Clear during a redirect wins over increment
    drive(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 1'b1);
    chk("clrbr.redirect", {31'd0, bus.redirect}, 32'd1);
    tick();
    idle();
    chk("clrbr.count", {16'd0, bus.br_count}, 32'd0);
    check_state("clrbr.flush", 32'h60, 1'b1, 1'b0);
    tick();

    // PC wrap from all-ones in RUN
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check_state("wrap.ones", 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    check_state("wrap.zero", 32'h0, 1'b0, 1'b0);

    // Reset asserted while in WAIT_CC with a taken branch presented
    drive(1'b1, 1'b0, 32'h70, 1'b1, 1'b0, 1'b0);
    tick();
    check_state("mid.wait", 32'h0, 1'b0, 1'b1);
    chk("mid.count_pre", {16'd0, bus.br_count}, 32'd1);
    drive(1'b1, 1'b1, 32'h70, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_state("mid.rst", RESET_PC, 1'b0, 1'b0);
    chk("mid.redirect", {31'd0, bus.redirect}, 32'd0);
    chk("mid.count", {16'd0, bus.br_count}, 32'd0);
    tick();
    check_state("mid.rst_edge", RESET_PC, 1'b0, 1'b0);
    idle();
    rst = 1'b0;
    tick();
    check_state("post_rst", RESET_PC + 32'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001: Parameter PC_W, default 32, width of the program counter and branch target.
REQ-002: Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  reset, asynchronous and active-high.
REQ-005: stall  input  1  pipeline stall from the hazard unit; freezes the PC, FSM and counter.
REQ-006: br_valid  input  1  the decode stage holds a conditional branch.
REQ-007: branch_taken  input  1  condition-check result for the branch in decode; valid only while br_valid is 1.
REQ-008: br_target  input  PC_W  branch target address, valid while br_valid is 1.
REQ-009: cc_pending  input  1  the instruction in execute updates the condition-code flags at the next edge.
REQ-010: cnt_clr  input  1  synchronous clear of br_count.
REQ-011: pc  output  PC_W  registered fetch address, word-addressed.
REQ-012: if_flush  output  1  squash the instruction in the IF/ID latch.
REQ-013: hold_dec  output  1  hold the decode stage and inject a bubble into execute.
REQ-014: redirect  output  1  combinational pulse, high in any cycle whose edge loads pc with br_target.
REQ-015: br_count  output  16  saturating count of taken branches.

Function
REQ-016: The block SHALL implement a three-state FSM with states RUN, WAIT_CC and FLUSH.
REQ-017: Outputs by state, combinational on state: if_flush=1 only in FLUSH; hold_dec=1 only in WAIT_CC.
REQ-018: RUN with stall=0:
- br_valid=1 and cc_pending=1: go to WAIT_CC, pc holds.
- otherwise br_valid=1 and branch_taken=1: pc<=br_target, redirect=1, go to FLUSH.
- otherwise: pc<=pc+1, stay in RUN.
REQ-019: WAIT_CC with stall=0; cc_pending is ignored, and branch_taken now reflects the updated flags:
- br_valid=1 and branch_taken=1: pc<=br_target, redirect=1, go to FLUSH.
- otherwise: pc<=pc+1, go to RUN.
REQ-020: FLUSH with stall=0: pc<=pc+1, go to RUN; br_valid and branch_taken are ignored, since decode content is squashed.
REQ-021: When stall=1 in any state:
- pc, state and br_count hold.
- redirect=0.
- if_flush and hold_dec keep their state-defined values.
REQ-022: Taken-branch path: the redirect edge loads the target, and exactly one if_flush cycle follows the redirect edge; fetch of the target therefore costs one bubble.
REQ-023: A branch that is not taken costs no bubble in RUN and one cycle when it waited in WAIT_CC.
REQ-024: pc+1 SHALL wrap modulo 2^PC_W; all-ones advances to 0.
REQ-025: br_count SHALL increment by 1 on every edge where redirect=1 and saturate at 16'hFFFF.
REQ-026: cnt_clr=1 SHALL set br_count to 0 at the edge, taking priority over increment and over stall.
REQ-027: A branch with br_target equal to pc+1 SHALL still be treated as taken: redirect, flush and count.
REQ-028: Unused FSM encodings SHALL recover to RUN on the next edge.

Reset
REQ-029: While rst=1, asynchronously:
- pc=RESET_PC, state=RUN, br_count=0.
- if_flush=0, hold_dec=0, redirect=0.
REQ-030: Reset asserted in WAIT_CC or FLUSH SHALL abandon the pending branch or flush with no redirect.
REQ-031: On the first edge after rst deasserts with stall=0 and br_valid=0, pc SHALL become RESET_PC+1.

Verification
REQ-032: Sequential fetch:
- Stimulus: reset with RESET_PC=0x100, then 4 idle cycles.
- Response: pc goes 0x100, 0x101, 0x102, 0x103, 0x104; if_flush=0 throughout.
REQ-033: Taken branch:
- Stimulus: pc=0x20, br_valid=1, branch_taken=1, br_target=0x80.
- Response: redirect=1 in that cycle; next cycle pc=0x80 with if_flush=1; then pc=0x81; br_count=1.
REQ-034: Flag hazard:
- Stimulus: pc=0x10, br_valid=1, cc_pending=1.
- Response: hold_dec=1 for one cycle with pc=0x10. Then, with branch_taken=0, pc=0x11 and state RUN; or, with branch_taken=1 and br_target=0x40, pc=0x40 and then if_flush=1.
REQ-035: Stall:
- Stimulus: stall=1 for 3 cycles in FLUSH.
- Response: pc unchanged and if_flush=1 for all 3 cycles; RUN is reached one cycle after stall drops.
REQ-036: Counter saturation and wrap:
- Stimulus: preload br_count to 0xFFFE, then take 3 branches.
- Response: br_count ends at 0xFFFF; cnt_clr=1 during a redirect gives 0.
- Also: pc=all-ones with no branch gives pc=0.
REQ-037: Reset mid-operation:
- Stimulus: assert rst during WAIT_CC.
- Response: immediately pc=RESET_PC, hold_dec=0, br_count=0, no redirect.
